// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: deframer state encoding, oversample ratio and baud divisor.
// The oversample constant is shared so a future transmitter uses the same bit timing.
package uart_rx_fifo_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // round(clk_freq / (OVERSAMPLE * baud))
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned w_den;
        w_den = OVERSAMPLE * baud;
        return (clk_freq + w_den / 2) / w_den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_head without a read strobe.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead FIFO,
// plus sticky overrun and framing-error flags for the CPU side.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [7:0]             rd_data,
    output logic                   data_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   frame_err
);

    import uart_rx_fifo_pkg::*;

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [1:0]       r_sync;
    logic             w_rxd_s;
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    rx_state_e        r_state;
    logic [3:0]       r_tcnt;
    logic [2:0]       r_bcnt;
    logic [7:0]       r_shift;
    logic             r_push;
    logic [7:0]       r_push_data;
    logic             r_frame_err;
    logic             r_overrun;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_overrun_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rxd};
    end
    assign w_rxd_s = r_sync[1];

    // Held at zero while waiting so the sampling phase locks to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (r_state == ST_IDLE || r_state == ST_BREAK || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end
    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (clr_err) r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= ST_START;
                        r_tcnt  <= '0;
                        r_bcnt  <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd7) begin
                            r_tcnt  <= '0;
                            r_state <= w_rxd_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
                            r_shift <= {w_rxd_s, r_shift[7:1]};
                            r_bcnt  <= r_bcnt + 3'd1;
                            if (r_bcnt == 3'd7) r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
                            if (w_rxd_s) begin
                                r_push      <= 1'b1;
                                r_push_data <= r_shift;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rxd_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (rd_en),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count)
    );

    // A simultaneous pop makes room, so only an unpopped full FIFO drops the byte.
    assign w_overrun_evt = r_push && w_full && !rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_overrun <= 1'b0;
        else if (w_overrun_evt) r_overrun <= 1'b1;
        else if (clr_err)       r_overrun <= 1'b0;
    end

    assign data_ready = !w_empty;
    assign rd_data    = w_empty ? 8'h00 : w_head;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a serial driver queues expected bytes, a reader
// process pops the DUT and compares against the queue.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 15625;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DIV      = 4;
    localparam int unsigned BIT_CLK  = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       data_ready;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         reader_on = 1'b0;
    bit         spurious_on = 1'b0;
    bit         exp_ovr;
    bit         exp_fe;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .data_ready (data_ready),
        .count      (count),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8N1 frame, LSB first; stop_ok=0 holds the stop level low for two bit times.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (stop_ok ? BIT_CLK : 2 * BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (BIT_CLK) @(negedge clk);
    endtask

    // Good frame whose byte the model expects the FIFO to accept unless already full.
    task automatic send_good(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      exp_ovr = 1'b1;
        send_frame(b, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        reader_on = 1'b1;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d bytes never delivered", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        reader_on = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Monitor / reader: pops whenever enabled and data is present.
    initial begin
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (reader_on) begin
                if (data_ready) begin
                    if ($urandom_range(0, 3) != 0) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_byte: got 0x%0h, expected none", rd_data);
                        end else begin
                            check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                        end
                        rd_en = 1'b1;
                    end
                end else if (spurious_on && $urandom_range(0, 7) == 0) begin
                    rd_en = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", {rd_data, data_ready, count, overrun, frame_err}, 32'h0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_outputs", {rd_data, data_ready, count, overrun, frame_err}, 32'h0);
        end

        // Single byte
        send_good(8'h55);
        repeat (4) @(negedge clk);
        check("single_ready", data_ready, 1);
        check("single_count", count, 1);
        check("single_head", rd_data, 8'h55);
        drain("single_pop");
        check("single_count_after", count, 0);
        check("single_ready_after", data_ready, 0);

        // Start glitch
        rxd = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (20 * BIT_CLK) @(negedge clk);
        check("glitch_count", count, 0);
        check("glitch_flags", {overrun, frame_err}, 0);

        // Framing error, then recovery
        send_frame(8'hA3, 1'b0);
        check("frame_err_set", frame_err, 1);
        check("frame_count", count, 0);
        send_good(8'h3C);
        drain("after_frame");
        check("frame_err_sticky", frame_err, 1);
        pulse_clr();
        check("frame_err_clr", frame_err, 0);

        // Overrun: 17 bytes with no reads
        for (int i = 0; i <= 16; i++) send_good(8'(i));
        repeat (4) @(negedge clk);
        check("ovr_count", count, DEPTH);
        check("ovr_flag", overrun, exp_ovr);
        drain("ovr_pops");
        check("ovr_empty", data_ready, 0);
        check("ovr_rd_data_zero", rd_data, 0);
        pulse_clr();
        check("ovr_clr", overrun, 0);
        exp_ovr = 1'b0;

        // Reset during data bit 4 of 0xF0
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * BIT_CLK + 20) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check("midreset_outputs", {rd_data, data_ready, count, overrun, frame_err}, 0);
                rst = 1'b0;
            end
        join
        repeat (2 * BIT_CLK) @(negedge clk);
        check("midreset_after", {data_ready, count, overrun, frame_err}, 0);
        send_good(8'h81);
        drain("midreset_next");

        // Random traffic with concurrent reader and occasional bad stop bits
        reader_on   = 1'b1;
        spurious_on = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                exp_fe = 1'b1;
                send_frame(b, 1'b0);
            end else begin
                send_good(b);
            end
            repeat ($urandom_range(0, 2 * BIT_CLK)) @(negedge clk);
        end
        drain("random_drain");
        spurious_on = 1'b0;
        check("random_frame_err", frame_err, exp_fe);
        check("random_overrun", overrun, exp_ovr);
        check("random_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
